row_mac_sequencer: RTL and testbench
====================================

ROW_MAC_SEQUENCER -- requirements
Module: row_mac_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter ACC_W, default 24, accumulator width in bits (ACC_W >= 2*WIDTH).
REQ-003 Parameter CNT_W, default 8, width of the vector-length field.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  begins a dot-product job; sampled only in IDLE.
REQ-007 len  input  CNT_W  number of operand pairs; latched on an accepted start.
REQ-008 in_valid  input  1  operand pair a_in/x_in is valid.
REQ-009 in_ready  output  1  block accepts an operand pair this cycle.
REQ-010 a_in  input  WIDTH  multiplicand, unsigned.
REQ-011 x_in  input  WIDTH  multiplier, unsigned.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 out_valid  output  1  single-cycle pulse marking acc_out as final.
REQ-014 acc_out  output  ACC_W  accumulated sum of products.
REQ-015 overflow  output  1  sticky flag: the accumulator wrapped during the current job.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, MUL, ACC and DONE.
REQ-017 IDLE: start=1 with len!=0 SHALL latch len into remaining, clear acc_out and overflow, and go to FETCH.
REQ-018 IDLE: start=1 with len==0 SHALL clear acc_out and overflow and go to DONE.
REQ-019 in_ready SHALL equal 1 only in FETCH; a transfer occurs when in_valid & in_ready.
REQ-020 FETCH: a transfer SHALL latch a_in/x_in, clear the product register and bit index, and go to MUL; with no transfer the FSM SHALL stay in FETCH indefinitely.
REQ-021 MUL: each cycle SHALL add (a & {WIDTH{x[i]}}) << i into the 2*WIDTH product register (one array row per cycle), then increment i.
REQ-022 MUL SHALL last exactly WIDTH cycles; the cycle with i == WIDTH-1 SHALL go to ACC.
REQ-023 ACC: acc_out <= acc_out + product modulo 2^ACC_W, set overflow if a carry leaves bit ACC_W-1, and decrement remaining.
REQ-024 ACC with remaining==1 before the decrement SHALL go to DONE; otherwise it SHALL go to FETCH.
REQ-025 DONE: out_valid=1 for exactly one cycle, then go to IDLE.
REQ-026 Each element SHALL take WIDTH+2 cycles with in_valid held high; for a start at cycle t, out_valid SHALL occur at cycle t+1+len*(WIDTH+2).
REQ-027 acc_out and overflow SHALL hold their values after DONE until the next accepted start or reset.
REQ-028 start SHALL be ignored outside IDLE; in_valid SHALL be ignored outside FETCH.
REQ-029 busy SHALL be combinational from the state (0 only in IDLE).

Reset
REQ-030 rst=1 at any clock edge, including mid-MUL or mid-ACC, SHALL force IDLE and clear acc_out, overflow, out_valid, in_ready, busy, the product register, remaining and the bit index.
REQ-031 While rst is high the block SHALL accept no operand pair and no start.
REQ-032 The first start SHALL be honoured on the first edge after rst deasserts.

Verification
REQ-033 len=1, a=3, x=5, in_valid held high, start at cycle 0 -> out_valid at cycle 11, acc_out=15, overflow=0.
REQ-034 len=3, pairs (255,255), (1,2), (10,10) -> acc_out=65127, out_valid at cycle 31, in_ready high exactly 3 cycles.
REQ-035 ACC_W=16, len=2, pairs (255,255), (255,255) -> acc_out=64514, overflow=1, still held 5 cycles after DONE.
REQ-036 in_valid withheld for 7 cycles in FETCH -> in_ready stays 1, no state change; result correct; out_valid delayed by 7 cycles.
REQ-037 start with len=0 -> out_valid one cycle later, acc_out=0, in_ready never asserted.
REQ-038 rst pulsed during the 4th MUL cycle -> next cycle busy=0 and acc_out=0; a new job of (2,3) then returns 6.

Source files
------------

// File: rtl/row_mac_sequencer.sv
// row_mac_sequencer
//
// Sequential dot-product engine. A job is started with a vector length;
// the block then accepts that many unsigned operand pairs through a
// valid/ready handshake. It multiplies each pair with a shift-and-add
// array, one partial-product row per cycle, and adds each product into a
// wrapping accumulator. A sticky flag records whether the accumulator
// wrapped during the job.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   start      begin a job (only looked at while idle)
//   len        number of operand pairs, latched when a job starts
//   in_valid   a_in / x_in carry a valid operand pair
//   in_ready   the block takes an operand pair this cycle (FETCH only)
//   a_in       multiplicand, unsigned
//   x_in       multiplier, unsigned
//   busy       high in every state except IDLE
//   out_valid  one-cycle pulse: acc_out holds the final sum
//   acc_out    accumulated sum of products, modulo 2^ACC_W
//   overflow   sticky: the accumulator wrapped during the current job
//
// Timing: a start seen at cycle t gives FETCH at t+1. Each element takes
// WIDTH+2 cycles (FETCH, WIDTH x MUL, ACC) while in_valid is held high.
// DONE, and therefore out_valid, falls at t+1+len*(WIDTH+2).

module row_mac_sequencer #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] x_in,
    output logic             busy,
    output logic             out_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MUL,
        S_ACC,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  x_reg;
    logic [PROD_W-1:0] product;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  remaining;

    logic [PROD_W-1:0] row;
    logic [ACC_W:0]    acc_sum;
    logic              last_row;

    // One row of the multiplier array: the multiplicand gated by the current
    // multiplier bit, shifted into place.
    assign row      = PROD_W'(a_reg & {WIDTH{x_reg[bit_idx]}}) << bit_idx;
    assign last_row = (bit_idx == IDX_W'(WIDTH - 1));

    // The extra top bit is the carry out of the accumulator.
    assign acc_sum  = {1'b0, acc_out} + (ACC_W + 1)'(product);

    // NOTE: every output and next-state value gets a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        out_valid  = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (len != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (last_row) begin
                    state_next = S_ACC;
                end
            end
            S_ACC: begin
                state_next = (remaining == CNT_W'(1)) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                out_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: reset is synchronous and clears the whole datapath, not just the
    // FSM, so a reset in the middle of MUL or ACC leaves no stale product,
    // count or accumulator behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            x_reg     <= '0;
            product   <= '0;
            bit_idx   <= '0;
            remaining <= '0;
            acc_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_out   <= '0;
                        overflow  <= 1'b0;
                        remaining <= len;
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        a_reg   <= a_in;
                        x_reg   <= x_in;
                        product <= '0;
                        bit_idx <= '0;
                    end
                end
                S_MUL: begin
                    product <= product + row;
                    bit_idx <= bit_idx + IDX_W'(1);
                end
                S_ACC: begin
                    acc_out   <= acc_sum[ACC_W-1:0];
                    overflow  <= overflow | acc_sum[ACC_W];
                    remaining <= remaining - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_mac_sequencer.sv
// tb_row_mac_sequencer
//
// Directed bench for row_mac_sequencer (WIDTH=8, ACC_W=16, CNT_W=8).
// Inputs are driven and outputs sampled on the falling edge. Cycle numbers
// count rising edges after the cycle in which start is driven (cycle 0).

module tb_row_mac_sequencer;

    localparam int WIDTH = 8;
    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] x_in;
    logic             busy;
    logic             out_valid;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] pa [0:3];
    logic [WIDTH-1:0] px [0:3];

    row_mac_sequencer #(
        .WIDTH(WIDTH),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .x_in     (x_in),
        .busy     (busy),
        .out_valid(out_valid),
        .acc_out  (acc_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one job. Operand pairs come from pa/px. gap withholds in_valid for
    // that many FETCH cycles before the first transfer. Outside FETCH in_valid
    // is held high with junk operands, which the block must ignore. With poke
    // set, start is raised (len=5) on every busy cycle, which must be ignored.
    // done_cyc is -1 if out_valid never arrives within the cycle budget.
    task automatic run_job(input int n, input int gap, input bit poke,
                           output int done_cyc, output int rdy_cnt,
                           output logic [ACC_W-1:0] acc_seen,
                           output logic ovf_seen);
        int k;
        int gap_left;
        k        = 0;
        gap_left = gap;
        rdy_cnt  = 0;
        done_cyc = -1;
        acc_seen = 'x;
        ovf_seen = 1'bx;
        @(negedge clk);
        start    = 1'b1;
        len      = CNT_W'(n);
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                done_cyc = cyc;
                acc_seen = acc_out;
                ovf_seen = overflow;
                break;
            end
            if (poke && busy) begin
                start = 1'b1;
                len   = CNT_W'(5);
            end
            if (in_ready) begin
                rdy_cnt++;
                if (gap_left > 0) begin
                    gap_left--;
                    in_valid = 1'b0;
                end else if (k < n) begin
                    a_in     = pa[k];
                    x_in     = px[k];
                    in_valid = 1'b1;
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                in_valid = 1'b1;
                a_in     = 8'hA5;
                x_in     = 8'h5A;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        len      = 8'd1;
        in_valid = 1'b1;
        a_in     = 8'd7;
        x_in     = 8'd7;
        repeat (3) @(negedge clk);
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (acc_out !== 16'd0) begin
            errors++; $display("FAIL reset_acc_out: got %0d expected 0", acc_out);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %b expected 0", overflow);
        end
        checks++;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int d, r;
        logic [ACC_W-1:0] acc;
        logic ovf;
        pa[0] = 8'd3; px[0] = 8'd5;
        run_job(1, 0, 1'b0, d, r, acc, ovf);
        if (d !== 11) begin
            errors++; $display("FAIL single_done_cycle: got %0d expected 11", d);
        end
        checks++;
        if (acc !== 16'd15) begin
            errors++; $display("FAIL single_acc: got %0d expected 15", acc);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL single_overflow: got %b expected 0", ovf);
        end
        checks++;
        if (r !== 1) begin
            errors++; $display("FAIL single_ready_cycles: got %0d expected 1", r);
        end
        checks++;
        @(negedge clk);
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_pulse_width: out_valid got %b expected 0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_idle_after: busy got %b expected 0", busy);
        end
        checks++;
        if (acc_out !== 16'd15) begin
            errors++; $display("FAIL single_hold: got %0d expected 15", acc_out);
        end
        checks++;
    endtask

    task automatic test_overflow();
        int d, r;
        logic [ACC_W-1:0] acc;
        logic ovf;
        pa[0] = 8'd255; px[0] = 8'd255;
        pa[1] = 8'd255; px[1] = 8'd255;
        run_job(2, 0, 1'b0, d, r, acc, ovf);
        if (d !== 21) begin
            errors++; $display("FAIL ovf_done_cycle: got %0d expected 21", d);
        end
        checks++;
        if (acc !== 16'd64514) begin
            errors++; $display("FAIL ovf_acc: got %0d expected 64514", acc);
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_flag: got %b expected 1", ovf);
        end
        checks++;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (acc_out !== 16'd64514 || overflow !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL ovf_hold_%0d: acc %0d ovf %b out_valid %b expected 64514 1 0",
                         i, acc_out, overflow, out_valid);
            end
            checks++;
        end
    endtask

    task automatic test_multi();
        int d, r;
        logic [ACC_W-1:0] acc;
        logic ovf;
        pa[0] = 8'd255; px[0] = 8'd255;
        pa[1] = 8'd1;   px[1] = 8'd2;
        pa[2] = 8'd10;  px[2] = 8'd10;
        run_job(3, 0, 1'b0, d, r, acc, ovf);
        if (d !== 31) begin
            errors++; $display("FAIL multi_done_cycle: got %0d expected 31", d);
        end
        checks++;
        if (acc !== 16'd65127) begin
            errors++; $display("FAIL multi_acc: got %0d expected 65127", acc);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL multi_overflow_cleared: got %b expected 0", ovf);
        end
        checks++;
        if (r !== 3) begin
            errors++; $display("FAIL multi_ready_cycles: got %0d expected 3", r);
        end
        checks++;
    endtask

    task automatic test_stall();
        int d, r;
        logic [ACC_W-1:0] acc;
        logic ovf;
        pa[0] = 8'd4; px[0] = 8'd6;
        pa[1] = 8'd9; px[1] = 8'd11;
        run_job(2, 7, 1'b0, d, r, acc, ovf);
        if (d !== 28) begin
            errors++; $display("FAIL stall_done_cycle: got %0d expected 28", d);
        end
        checks++;
        if (acc !== 16'd123) begin
            errors++; $display("FAIL stall_acc: got %0d expected 123", acc);
        end
        checks++;
        if (r !== 9) begin
            errors++; $display("FAIL stall_ready_cycles: got %0d expected 9", r);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL stall_overflow: got %b expected 0", ovf);
        end
        checks++;
    endtask

    task automatic test_len_zero();
        int d, r;
        logic [ACC_W-1:0] acc;
        logic ovf;
        run_job(0, 0, 1'b0, d, r, acc, ovf);
        if (d !== 1) begin
            errors++; $display("FAIL len0_done_cycle: got %0d expected 1", d);
        end
        checks++;
        if (acc !== 16'd0) begin
            errors++; $display("FAIL len0_acc: got %0d expected 0", acc);
        end
        checks++;
        if (r !== 0) begin
            errors++; $display("FAIL len0_ready_cycles: got %0d expected 0", r);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL len0_overflow: got %b expected 0", ovf);
        end
        checks++;
    endtask

    task automatic test_reset_mid_job();
        int d;
        @(negedge clk);
        start    = 1'b1;
        len      = 8'd2;
        in_valid = 1'b0;
        // Element 0 (3,5): FETCH 1, MUL 2..9, ACC 10. Element 1 (7,7):
        // FETCH 11, MUL 12..19; cycle 15 is its 4th MUL cycle.
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
            a_in     = (cyc < 10) ? 8'd3 : 8'd7;
            x_in     = (cyc < 10) ? 8'd5 : 8'd7;
        end
        if (busy !== 1'b1 || acc_out !== 16'd15) begin
            errors++; $display("FAIL midjob_before_rst: busy %b acc %0d expected 1 15", busy, acc_out);
        end
        checks++;
        rst = 1'b1;
        @(negedge clk);
        if (busy !== 1'b0) begin
            errors++; $display("FAIL midjob_rst_busy: got %b expected 0", busy);
        end
        checks++;
        if (acc_out !== 16'd0) begin
            errors++; $display("FAIL midjob_rst_acc: got %0d expected 0", acc_out);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL midjob_rst_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        start    = 1'b1;
        len      = 8'd1;
        a_in     = 8'd2;
        x_in     = 8'd3;
        in_valid = 1'b1;
        @(negedge clk);
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_blocks_start: busy got %b expected 0", busy);
        end
        checks++;
        rst = 1'b0;
        @(negedge clk);
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL first_start_after_rst: in_ready got %b expected 1", in_ready);
        end
        checks++;
        start = 1'b0;
        d = -1;
        // FETCH at cycle 1 here, MUL 2..9, ACC 10, DONE 11.
        for (int cyc = 2; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                d = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        if (d !== 11) begin
            errors++; $display("FAIL after_rst_done_cycle: got %0d expected 11", d);
        end
        checks++;
        if (acc_out !== 16'd6) begin
            errors++; $display("FAIL after_rst_acc: got %0d expected 6", acc_out);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int d, r;
        logic [ACC_W-1:0] acc;
        logic ovf;
        pa[0] = 8'd200; px[0] = 8'd100;
        pa[1] = 8'd17;  px[1] = 8'd3;
        run_job(2, 0, 1'b1, d, r, acc, ovf);
        if (d !== 21) begin
            errors++; $display("FAIL b2b_first_done_cycle: got %0d expected 21", d);
        end
        checks++;
        if (acc !== 16'd20051) begin
            errors++; $display("FAIL b2b_first_acc: got %0d expected 20051", acc);
        end
        checks++;
        pa[0] = 8'd6; px[0] = 8'd7;
        run_job(1, 0, 1'b0, d, r, acc, ovf);
        if (d !== 11) begin
            errors++; $display("FAIL b2b_second_done_cycle: got %0d expected 11", d);
        end
        checks++;
        if (acc !== 16'd42) begin
            errors++; $display("FAIL b2b_second_acc: got %0d expected 42", acc);
        end
        checks++;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        a_in     = '0;
        x_in     = '0;
        test_reset();
        test_single();
        test_overflow();
        test_multi();
        test_stall();
        test_len_zero();
        test_reset_mid_job();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
